// File: rtl/timer_counter.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers behind the CPU bridge,
// one-shot (mode 00) or auto-reload (mode 01) countdown, level interrupt gated by IM.
module timer_counter #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CNT,
        S_INT
    } state_t;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_PRESET  = 2'd1;
    localparam logic [1:0] REG_COUNT   = 2'd2;
    localparam logic [1:0] MODE_RELOAD = 2'b01;

    state_t           r_state;
    state_t           w_stateNext;
    logic             r_enable;
    logic [1:0]       r_mode;
    logic             r_im;
    logic [CNT_W-1:0] r_preset;
    logic [CNT_W-1:0] r_count;
    logic             r_irqFlag;

    logic             w_wrCtrl;
    logic             w_wrPreset;
    logic             w_load;
    logic             w_dec;
    logic             w_expire;
    logic             w_autoDisable;
    logic             w_reloadAck;
    logic             w_unusedAddr;

    assign w_wrCtrl     = WE && (Addr[3:2] == REG_CTRL);
    assign w_wrPreset   = WE && (Addr[3:2] == REG_PRESET);
    assign w_unusedAddr = ^{Addr[31:4], Addr[1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // The FSM sees the registered Enable, so a CPU write acts from the following edge.
    always_comb begin
        w_stateNext   = r_state;
        w_load        = 1'b0;
        w_dec         = 1'b0;
        w_expire      = 1'b0;
        w_autoDisable = 1'b0;
        w_reloadAck   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_enable) begin
                    w_stateNext = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!r_enable) begin
                    w_stateNext = S_IDLE;
                end else begin
                    w_load      = 1'b1;
                    w_stateNext = S_CNT;
                end
            end
            S_CNT: begin
                if (!r_enable) begin
                    w_stateNext = S_IDLE;
                end else if (r_count > CNT_W'(1)) begin
                    w_dec = 1'b1;
                end else begin
                    w_expire    = 1'b1;
                    w_stateNext = S_INT;
                end
            end
            S_INT: begin
                if (r_mode == MODE_RELOAD) begin
                    w_reloadAck = 1'b1;
                    w_stateNext = S_LOAD;
                end else begin
                    w_autoDisable = 1'b1;
                    w_stateNext   = S_IDLE;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // A CPU write to CTRL takes priority over the one-shot auto-disable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_enable <= 1'b0;
            r_mode   <= 2'b00;
            r_im     <= 1'b0;
        end else if (w_wrCtrl) begin
            r_enable <= Din[0];
            r_mode   <= Din[2:1];
            r_im     <= Din[3];
        end else if (w_autoDisable) begin
            r_enable <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_preset <= '0;
        end else if (w_wrPreset) begin
            r_preset <= Din[CNT_W-1:0];
        end
    end

    // COUNT is never written by the CPU; the decrement stops at 0 so it cannot wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (w_load) begin
            r_count <= r_preset;
        end else if (w_dec) begin
            r_count <= r_count - CNT_W'(1);
        end else if (w_expire) begin
            r_count <= '0;
        end
    end

    // Expiry wins over a coincident register write so an interrupt is never lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irqFlag <= 1'b0;
        end else if (w_expire) begin
            r_irqFlag <= 1'b1;
        end else if (w_wrCtrl || w_wrPreset || w_reloadAck) begin
            r_irqFlag <= 1'b0;
        end
    end

    always_comb begin
        Dout = '0;
        case (Addr[3:2])
            REG_CTRL:   Dout = {28'd0, r_im, r_mode, r_enable};
            REG_PRESET: Dout = 32'(r_preset);
            REG_COUNT:  Dout = 32'(r_count);
            default:    Dout = '0;
        endcase
    end

    assign IRQ = r_irqFlag & r_im;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: the driver pushes hand-computed expectations into a
// scoreboard queue and a separate monitor pops and compares on each sample strobe.
module tb_timer_counter;

    typedef struct {
        logic [31:0] expDout;
        bit          chkIrq;
        logic        expIrq;
    } expect_t;

    localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
    localparam logic [31:0] A_PRESET = 32'h0000_7F04;
    localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
    localparam logic [31:0] A_RSVD   = 32'h0000_7F0C;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;
    logic        sampleReq;

    expect_t     sbQ[$];
    string       sbName[$];
    expect_t     mEntry;
    string       mName;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    timer_counter #(.CNT_W(32)) dut (
        .clk  (clk),
        .reset(reset),
        .Addr (Addr),
        .WE   (WE),
        .Din  (Din),
        .Dout (Dout),
        .IRQ  (IRQ)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
        Addr = addr;
        Din  = data;
        WE   = 1'b1;
        tick();
        WE   = 1'b0;
        Din  = '0;
    endtask

    // Queue an expectation, then strobe the monitor either now or at this cycle's negedge.
    task automatic checkOutput(input string name, input logic [31:0] addr, input logic [31:0] expD,
                               input bit chkIrq, input logic expIrq, input bit immediate);
        expect_t e;
        e.expDout = expD;
        e.chkIrq  = chkIrq;
        e.expIrq  = expIrq;
        Addr = addr;
        sbQ.push_back(e);
        sbName.push_back(name);
        if (immediate) begin
            #1;
        end else begin
            @(negedge clk);
        end
        sampleReq = 1'b1;
        #1;
        sampleReq = 1'b0;
    endtask

    function automatic logic [31:0] m1Count(input int k);
        int p;
        if (k < 2) return 32'd0;
        p = (k - 2) % 5;
        case (p)
            0:       return 32'd3;
            1:       return 32'd2;
            2:       return 32'd1;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge sampleReq) begin
        if (sbQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboardEmpty: sample strobe got no entry, required one");
        end else begin
            mEntry = sbQ.pop_front();
            mName  = sbName.pop_front();
            total++;
            if (Dout !== mEntry.expDout) begin
                bad++;
                $display("[TB] FAIL %s: Dout got 0x%08h required 0x%08h", mName, Dout, mEntry.expDout);
            end
            if (mEntry.chkIrq) begin
                total++;
                if (IRQ !== mEntry.expIrq) begin
                    bad++;
                    $display("[TB] FAIL %s: IRQ got %b required %b", mName, IRQ, mEntry.expIrq);
                end
            end
        end
    end

    initial begin
        #100000;
        bad++;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b0;
        WE        = 1'b0;
        Addr      = '0;
        Din       = '0;
        sampleReq = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        checkOutput("rstCtrl", A_CTRL, 32'd0, 1, 1'b0, 0); tick();
        checkOutput("rstPreset", A_PRESET, 32'd0, 1, 1'b0, 0); tick();
        checkOutput("rstCount", A_COUNT, 32'd0, 1, 1'b0, 0); tick();

        // Mode 00 one-shot, PRESET=5: IRQ rises on the 7th edge after the CTRL write.
        applyStimulus(A_PRESET, 32'd5);
        Addr = A_CTRL;
        Din  = 32'h9;
        WE   = 1'b1;
        checkOutput("ctrlOldOnWrite", A_CTRL, 32'd0, 1, 1'b0, 0);
        tick();
        WE  = 1'b0;
        Din = '0;
        checkOutput("m0Idle", A_COUNT, 32'd0, 1, 1'b0, 0); tick();
        checkOutput("m0Load", A_COUNT, 32'd0, 1, 1'b0, 0); tick();
        for (int v = 5; v >= 1; v--) begin
            checkOutput("m0Count", A_COUNT, 32'(v), 1, 1'b0, 0);
            tick();
        end
        checkOutput("m0Expire", A_COUNT, 32'd0, 1, 1'b1, 0); tick();
        checkOutput("m0CtrlAfter", A_CTRL, 32'h8, 1, 1'b1, 0); tick();
        checkOutput("m0IrqHold", A_CTRL, 32'h8, 1, 1'b1, 0);
        applyStimulus(A_CTRL, 32'h0);
        checkOutput("m0Clear", A_CTRL, 32'h0, 1, 1'b0, 0);
        tick();

        // Mode 01 auto-reload, PRESET=3: one-cycle pulse every 5 cycles.
        applyStimulus(A_PRESET, 32'd3);
        applyStimulus(A_CTRL, 32'hB);
        for (int k = 1; k <= 17; k++) begin
            tick();
            checkOutput("m1Period", A_COUNT, m1Count(k), 1, ((k >= 2) && ((k - 2) % 5 == 3)), 0);
        end
        applyStimulus(A_CTRL, 32'h0);
        tick();
        checkOutput("m1Stop", A_COUNT, 32'd2, 1, 1'b0, 0);
        tick();

        // Masked expiry: IRQ stays low, and unmasking afterwards does not expose the flag.
        applyStimulus(A_PRESET, 32'd2);
        applyStimulus(A_CTRL, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            checkOutput("maskIrq", A_COUNT, (k <= 2) ? 32'd2 : ((k == 3) ? 32'd1 : 32'd0), 1, 1'b0, 0);
        end
        tick();
        checkOutput("maskCtrl", A_CTRL, 32'h0, 1, 1'b0, 0);
        applyStimulus(A_CTRL, 32'h8);
        checkOutput("maskUnmask", A_CTRL, 32'h8, 1, 1'b0, 0); tick();
        checkOutput("maskUnmask2", A_COUNT, 32'd0, 1, 1'b0, 0); tick();

        // Pause at COUNT=4, ignored writes, then resume via LOAD.
        applyStimulus(A_PRESET, 32'd7);
        applyStimulus(A_CTRL, 32'h9);
        tick();
        tick();
        checkOutput("pauseRun7", A_COUNT, 32'd7, 1, 1'b0, 0); tick();
        checkOutput("pauseRun6", A_COUNT, 32'd6, 1, 1'b0, 0); tick();
        checkOutput("pauseRun5", A_COUNT, 32'd5, 1, 1'b0, 0);
        applyStimulus(A_CTRL, 32'h8);
        checkOutput("pauseHoldA", A_COUNT, 32'd4, 1, 1'b0, 0); tick();
        checkOutput("pauseHoldB", A_COUNT, 32'd4, 1, 1'b0, 0);
        applyStimulus(A_COUNT, 32'h55);
        checkOutput("countWriteIgnored", A_COUNT, 32'd4, 1, 1'b0, 0);
        applyStimulus(A_RSVD, 32'hFFFF_FFFF);
        checkOutput("rsvdRead", A_RSVD, 32'd0, 0, 1'b0, 0); tick();
        checkOutput("rsvdNoCtrl", A_CTRL, 32'h8, 1, 1'b0, 0); tick();
        checkOutput("rsvdNoPreset", A_PRESET, 32'd7, 0, 1'b0, 0);
        applyStimulus(A_CTRL, 32'h9);
        tick();
        checkOutput("resumeLoad", A_COUNT, 32'd4, 1, 1'b0, 0); tick();
        checkOutput("resumeReload", A_COUNT, 32'd7, 1, 1'b0, 0);
        applyStimulus(A_PRESET, 32'd2);
        checkOutput("presetMidCount", A_COUNT, 32'd6, 1, 1'b0, 0);
        applyStimulus(A_CTRL, 32'h9);
        checkOutput("enableNoRestart", A_COUNT, 32'd5, 1, 1'b0, 0);
        for (int v = 4; v >= 1; v--) begin
            tick();
            checkOutput("resumeCount", A_COUNT, 32'(v), 1, 1'b0, 0);
        end
        tick();
        checkOutput("resumeExpire", A_COUNT, 32'd0, 1, 1'b1, 0); tick();
        checkOutput("resumeCtrl", A_CTRL, 32'h8, 1, 1'b1, 0);

        // CTRL write coincident with INT: the written Enable survives; new PRESET is used.
        applyStimulus(A_CTRL, 32'h9);
        checkOutput("coinStart", A_COUNT, 32'd0, 1, 1'b0, 0); tick();
        checkOutput("coinLoad", A_COUNT, 32'd0, 1, 1'b0, 0); tick();
        checkOutput("coinPreset", A_COUNT, 32'd2, 1, 1'b0, 0); tick();
        checkOutput("coinCount1", A_COUNT, 32'd1, 1, 1'b0, 0); tick();
        checkOutput("coinExpire", A_COUNT, 32'd0, 1, 1'b1, 0);
        applyStimulus(A_CTRL, 32'h9);
        checkOutput("coinCtrlWins", A_CTRL, 32'h9, 1, 1'b0, 0); tick();
        checkOutput("coinRestartLoad", A_COUNT, 32'd0, 1, 1'b0, 0); tick();
        checkOutput("coinRestart", A_COUNT, 32'd2, 1, 1'b0, 0);
        applyStimulus(A_CTRL, 32'h0);
        tick();
        checkOutput("coinStop", A_COUNT, 32'd1, 1, 1'b0, 0);

        // PRESET=0 behaves as 1: IRQ three edges after the CTRL write.
        applyStimulus(A_PRESET, 32'd0);
        applyStimulus(A_CTRL, 32'h9);
        checkOutput("p0Idle", A_COUNT, 32'd1, 1, 1'b0, 0); tick();
        checkOutput("p0Load", A_COUNT, 32'd1, 1, 1'b0, 0); tick();
        checkOutput("p0Cnt", A_COUNT, 32'd0, 1, 1'b0, 0); tick();
        checkOutput("p0Irq", A_COUNT, 32'd0, 1, 1'b1, 0);
        applyStimulus(A_CTRL, 32'h0);
        checkOutput("p0Clear", A_CTRL, 32'h0, 1, 1'b0, 0);

        // Maximum PRESET counts down without wrapping.
        applyStimulus(A_PRESET, 32'hFFFF_FFFF);
        applyStimulus(A_CTRL, 32'h1);
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            checkOutput("maxCount", A_COUNT, 32'hFFFF_FFFF - 32'(i), 0, 1'b0, 0);
            tick();
        end
        applyStimulus(A_CTRL, 32'h0);
        tick();

        // Asynchronous reset mid-count clears everything before the next edge.
        applyStimulus(A_PRESET, 32'd5);
        applyStimulus(A_CTRL, 32'h9);
        tick();
        tick();
        tick();
        tick();
        checkOutput("preResetCount", A_COUNT, 32'd3, 1, 1'b0, 1);
        reset = 1'b0;
        checkOutput("rstCountAsync", A_COUNT, 32'd0, 1, 1'b0, 1);
        checkOutput("rstCtrlAsync", A_CTRL, 32'd0, 1, 1'b0, 1);
        checkOutput("rstPresetAsync", A_PRESET, 32'd0, 1, 1'b0, 1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        checkOutput("postResetCount", A_COUNT, 32'd0, 1, 1'b0, 0); tick();
        checkOutput("postResetCtrl", A_CTRL, 32'd0, 1, 1'b0, 0); tick();

        tick();
        total++;
        if (sbQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboardDrain: pending=%0d required 0", sbQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
